dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-ported data memory between the sequential CPU's load/store path and a debug/loader port used by test infrastructure to preload and dump memory. Grants one access per cycle with round-robin fairness, supports a debug lock for exclusive bursts with a bounded-starvation yield slot for the CPU, and returns read data one cycle after the grant.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-ported data memory between the CPU load/store path
// and the debug/loader port. Round-robin arbitration, debug lock with a CPU yield slot.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              cpu_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK - 1);

    localparam logic [1:0] ARB    = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] YIELD  = 2'd2;

    logic [1:0]    state;
    logic          last_owner;
    logic [CW-1:0] lock_cnt;
    logic          rd_pending_c;
    logic          rd_pending_d;

    // Grants are gated by reset so every output is quiet while reset is held low.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            case (state)
                ARB: begin
                    if (c_req && d_req) begin
                        c_gnt = last_owner;
                        d_gnt = ~last_owner;
                    end else begin
                        c_gnt = c_req;
                        d_gnt = d_req;
                    end
                end
                LOCKED:  d_gnt = d_req;
                YIELD:   c_gnt = c_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        m_en    = c_gnt | d_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    assign cpu_stall = reset & c_req & ~c_gnt;
    assign c_rvalid  = rd_pending_c;
    assign d_rvalid  = rd_pending_d;
    assign c_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB;
            last_owner   <= 1'b1;
            lock_cnt     <= '0;
            rd_pending_c <= 1'b0;
            rd_pending_d <= 1'b0;
        end else begin
            rd_pending_c <= c_gnt & ~c_we;
            rd_pending_d <= d_gnt & ~d_we;
            if (c_gnt) begin
                last_owner <= 1'b0;
            end else if (d_gnt) begin
                last_owner <= 1'b1;
            end
            case (state)
                ARB: begin
                    if (d_gnt && d_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // Releasing the lock hands the next conflict to the CPU.
                    if (!d_lock) begin
                        state      <= ARB;
                        last_owner <= 1'b1;
                    end else if (lock_cnt == CNT_MAX && c_req) begin
                        state <= YIELD;
                    end else if (lock_cnt != CNT_MAX) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                YIELD: begin
                    lock_cnt <= '0;
                    state    <= d_lock ? LOCKED : ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbitration and
// memory model; directed phases cover reset, lock bursts, starvation and mid-read reset.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int ML = 4;

    logic          clk;
    logic          reset;
    logic          c_req, c_we, d_req, d_we, d_lock;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, cpu_stall, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the arbiter, driven only by the DUT's m_* outputs.
    logic [DW-1:0] mem [int];
    initial m_rdata = '0;
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[int'(m_addr)] = m_wdata;
            else m_rdata <= mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : '0;
        end
    end

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        int            due;
    } rd_t;
    rd_t sb[$];

    logic [DW-1:0] ref_mem [int];

    // Reference arbitration model
    bit locked, yield_slot, last_dbg;
    int lock_age;
    bit exp_cg, exp_dg;
    logic act_cg, act_dg, act_crv, act_drv, act_stall;
    logic [DW-1:0] act_crd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic model_reset();
        locked     = 1'b0;
        yield_slot = 1'b0;
        lock_age   = 0;
        last_dbg   = 1'b1;
    endtask

    task automatic eval();
        bit ecg, edg;
        logic [DW-1:0] ewd;
        logic [AW-1:0] ea;
        logic ewe;
        @(negedge clk);
        ecg = 1'b0;
        edg = 1'b0;
        if (yield_slot) ecg = c_req;
        else if (locked) edg = d_req;
        else if (c_req && d_req) begin
            ecg = last_dbg;
            edg = !last_dbg;
        end else begin
            ecg = c_req;
            edg = d_req;
        end
        ewe = ecg ? c_we : (edg ? d_we : 1'b0);
        ea  = ecg ? c_addr : (edg ? d_addr : '0);
        ewd = ecg ? c_wdata : (edg ? d_wdata : '0);

        act_cg = c_gnt; act_dg = d_gnt; act_crv = c_rvalid; act_drv = d_rvalid;
        act_crd = c_rdata; act_stall = cpu_stall;
        chk("c_gnt", 64'(c_gnt), 64'(ecg));
        chk("d_gnt", 64'(d_gnt), 64'(edg));
        chk("cpu_stall", 64'(cpu_stall), 64'(c_req & ~ecg));
        chk("m_en", 64'(m_en), 64'(ecg | edg));
        chk("m_we", 64'(m_we), 64'(ewe));
        chk("m_addr", 64'(m_addr), 64'(ea));
        chk("m_wdata", m_wdata, ewd);

        if (ecg || edg) begin
            if (ewe) ref_mem[int'(ea)] = ewd;
            else sb.push_back('{port: edg, data: ref_rd(ea), due: cyc + 1});
        end

        if (ecg) last_dbg = 1'b0;
        if (edg) last_dbg = 1'b1;
        if (yield_slot) begin
            yield_slot = 1'b0;
            if (!d_lock) locked = 1'b0;
            else lock_age = 0;
        end else if (locked) begin
            if (!d_lock) begin
                locked   = 1'b0;
                last_dbg = 1'b1;
            end else if (lock_age >= ML - 1 && c_req) yield_slot = 1'b1;
            else lock_age++;
        end else if (edg && d_lock) begin
            locked   = 1'b1;
            lock_age = 0;
        end
        exp_cg = ecg;
        exp_dg = edg;
    endtask

    task automatic step();
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_check();
        @(negedge clk);
        chk("rst_c_gnt", 64'(c_gnt), 0);
        chk("rst_d_gnt", 64'(d_gnt), 0);
        chk("rst_rvalid", 64'({c_rvalid, d_rvalid}), 0);
        chk("rst_stall", 64'(cpu_stall), 0);
        chk("rst_m_ctl", 64'({m_en, m_we}), 0);
        chk("rst_m_addr", 64'(m_addr), 0);
        chk("rst_m_wdata", m_wdata, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic rq, input logic we, input int a, input logic [DW-1:0] wd);
        c_req = rq; c_we = we; c_addr = AW'(a); c_wdata = wd;
    endtask

    task automatic set_d(input logic rq, input logic we, input logic lk, input int a,
                         input logic [DW-1:0] wd);
        d_req = rq; d_we = we; d_lock = lk; d_addr = AW'(a); d_wdata = wd;
    endtask

    // Monitor: every cycle either the oldest pending read is due, or no rvalid may show.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("c_rvalid", 64'(c_rvalid), 64'(!e.port));
                chk("d_rvalid", 64'(d_rvalid), 64'(e.port));
                chk(e.port ? "d_rdata" : "c_rdata", e.port ? d_rdata : c_rdata, e.data);
            end else begin
                chk("rvalid_idle", 64'({c_rvalid, d_rvalid}), 0);
            end
        end
    end

    initial begin
        bit exp_y;
        int lk_timer;
        reset = 1'b0;
        set_c(1, 0, 1, '0);
        set_d(1, 0, 1, 2, '0);
        model_reset();
        repeat (3) rst_check();

        // Release with both requesting: CPU first, then alternation
        reset = 1'b1;
        set_d(1, 0, 0, 2, '0);
        step(); chk("rr_first_cpu", 64'(act_cg), 1);
        set_c(1, 0, 3, '0);
        step(); chk("rr_then_dbg", 64'(act_dg), 1);
        set_d(1, 0, 0, 4, '0);
        step(); chk("rr_alt_cpu", 64'(act_cg), 1);
        set_c(1, 0, 6, '0);
        step(); chk("rr_alt_dbg", 64'(act_dg), 1);
        set_d(0, 0, 0, 0, '0);
        step();

        // CPU-only store then load
        set_c(1, 1, 5, 64'h0A);
        step(); chk("sd_m_we", 64'(act_cg), 1);
        set_c(1, 0, 5, '0);
        step(); chk("ld_gnt", 64'(act_cg), 1);
        set_c(0, 0, 0, '0);
        step();
        chk("ld_c_rvalid", 64'(act_crv), 1);
        chk("ld_c_rdata", act_crd, 64'h0A);
        chk("ld_d_rvalid", 64'(act_drv), 0);

        // Debug locked burst while the CPU waits
        set_c(1, 0, 7, '0);
        for (int i = 0; i < 4; i++) begin
            set_d(1, 1, 1, i, 64'(32'hD000 + i));
            step();
            chk("burst_stall", 64'(act_stall), 1);
            chk("burst_d_gnt", 64'(act_dg), 1);
        end
        set_d(0, 0, 0, 0, '0);
        step(); chk("unlock_stall", 64'(act_stall), 1);
        step(); chk("unlock_cpu_gnt", 64'(act_cg), 1);

        // Starvation bound: every 5th cycle belongs to the CPU
        set_c(1, 0, 8, '0);
        for (int i = 0; i < 12; i++) begin
            if (!yield_slot) set_d(1, 1, 1, 16 + i, 64'(i));
            exp_y = (i % 5 == 0) && (i > 0);
            step();
            chk("starve_c_gnt", 64'(act_cg), 64'(exp_y));
            chk("starve_d_gnt", 64'(act_dg), 64'(!exp_y));
            if (act_cg) set_c(1, 0, 9 + i, '0);
        end
        set_d(1, 1, 0, 40, 64'h55);
        step(); chk("lockdrop_d_gnt", 64'(act_dg), 1);
        set_d(1, 0, 0, 41, '0);
        step(); chk("lockdrop_cpu_wins", 64'(act_cg), 1);
        set_c(0, 0, 0, '0);
        step();
        set_d(0, 0, 0, 0, '0);
        step();

        // Reset in the middle of a locked debug read
        set_d(1, 0, 1, 40, '0);
        eval();
        chk("midrd_d_gnt", 64'(act_dg), 1);
        #1;
        reset = 1'b0;
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) rst_check();
        reset = 1'b1;
        set_c(1, 0, 10, '0);
        set_d(1, 0, 0, 11, '0);
        eval();
        chk("midrd_no_rvalid", 64'(act_drv), 0);
        chk("midrd_arb_cpu", 64'(act_cg), 1);
        @(posedge clk);
        #1;
        set_c(0, 0, 0, '0);
        step();

        // Randomized traffic
        lk_timer = 0;
        for (int n = 0; n < 600; n++) begin
            if (!c_req || exp_cg) begin
                set_c(($urandom % 4) != 0, $urandom % 2,
                      ($urandom % 4 == 0) ? int'($urandom % 1024) : int'($urandom % 16),
                      {$urandom, $urandom});
            end
            if (!d_req || exp_dg) begin
                set_d(($urandom % 3) != 0, $urandom % 2, d_lock,
                      ($urandom % 4 == 0) ? int'($urandom % 1024) : int'($urandom % 16),
                      {$urandom, $urandom});
            end
            if (lk_timer == 0) begin
                d_lock   = ($urandom % 3) == 0;
                lk_timer = $urandom_range(1, 12);
            end else begin
                lk_timer--;
            end
            step();
        end

        set_c(0, 0, 0, '0);
        set_d(0, 0, 0, 0, '0);
        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
